// File: rtl/priority_scanner_if.sv
// Request-vector input and beat output channels of the priority scanner.
// The scanner uses the slave side; the source/sink uses the master side.
interface priority_scanner_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] data_i;
    logic             data_val_i;
    logic             mode_i;
    logic             data_ready_o;
    logic [WIDTH-1:0] data_o;
    logic [IDX_W-1:0] index_o;
    logic             last_o;
    logic             empty_o;
    logic             data_val_o;
    logic             data_ready_i;

    modport slave (
        input  data_i, data_val_i, mode_i, data_ready_i,
        output data_ready_o, data_o, index_o, last_o, empty_o, data_val_o
    );

    modport master (
        output data_i, data_val_i, mode_i, data_ready_i,
        input  data_ready_o, data_o, index_o, last_o, empty_o, data_val_o
    );
endinterface

// File: rtl/priority_scanner.sv
// Serialises a request vector into one beat per set bit (one-hot + index),
// scanning MSB-first or LSB-first as chosen when the vector is accepted.
module priority_scanner #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               srst_i,
    priority_scanner_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mask_q;
    logic             dir_q;
    logic [WIDTH-1:0] data_q;
    logic [IDX_W-1:0] index_q;
    logic             last_q;
    logic             empty_q;
    logic             val_q;

    logic [WIDTH-1:0] src_mask;
    logic             src_dir;
    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_oh;
    logic             sel_last;
    logic             sel_empty;

    // Next beat: from the incoming vector in IDLE, else from the mask minus the bit being served.
    always_comb begin
        src_mask = (state_q == IDLE) ? bus.data_i : (mask_q & ~data_q);
        src_dir  = (state_q == IDLE) ? bus.mode_i : dir_q;
        sel_idx  = '0;
        if (src_dir) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (src_mask[i]) sel_idx = IDX_W'(i);
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (src_mask[i]) sel_idx = IDX_W'(i);
            end
        end
        sel_empty = (src_mask == '0);
        sel_oh    = sel_empty ? '0 : (ONE << sel_idx);
        // Zero or one bit set; an empty vector is also its own last beat.
        sel_last  = ((src_mask & (src_mask - ONE)) == '0);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            dir_q   <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            empty_q <= 1'b0;
            val_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.data_val_i) begin
                state_q <= SCAN;
                mask_q  <= bus.data_i;
                dir_q   <= bus.mode_i;
                data_q  <= sel_oh;
                index_q <= sel_idx;
                last_q  <= sel_last;
                empty_q <= sel_empty;
                val_q   <= 1'b1;
            end
        end else if (val_q && bus.data_ready_i) begin
            if (last_q) begin
                state_q <= IDLE;
                mask_q  <= '0;
                data_q  <= '0;
                index_q <= '0;
                last_q  <= 1'b0;
                empty_q <= 1'b0;
                val_q   <= 1'b0;
            end else begin
                mask_q  <= src_mask;
                data_q  <= sel_oh;
                index_q <= sel_idx;
                last_q  <= sel_last;
                empty_q <= sel_empty;
            end
        end
    end

    assign bus.data_ready_o = (state_q == IDLE);
    assign bus.data_o       = data_q;
    assign bus.index_o      = index_q;
    assign bus.last_o       = last_q;
    assign bus.empty_o      = empty_q;
    assign bus.data_val_o   = val_q;
endmodule

// File: tb/tb_priority_scanner.sv
// Bench for priority_scanner at WIDTH 8, 5 and 16: directed cases plus randomised
// transactions checked against an ordered list of set-bit indices.
module tb_priority_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    int          sel;
    logic [63:0] drv_data;
    logic        drv_val, drv_mode, drv_ready;

    priority_scanner_if #(.WIDTH(8))  b8 ();
    priority_scanner_if #(.WIDTH(5))  b5 ();
    priority_scanner_if #(.WIDTH(16)) b16 ();

    priority_scanner #(.WIDTH(8))  d8  (.clk_i(clk), .srst_i(srst), .bus(b8.slave));
    priority_scanner #(.WIDTH(5))  d5  (.clk_i(clk), .srst_i(srst), .bus(b5.slave));
    priority_scanner #(.WIDTH(16)) d16 (.clk_i(clk), .srst_i(srst), .bus(b16.slave));

    assign b8.data_i        = (sel == 8) ? drv_data[7:0] : '0;
    assign b8.data_val_i    = (sel == 8) && drv_val;
    assign b8.mode_i        = drv_mode;
    assign b8.data_ready_i  = (sel == 8) && drv_ready;
    assign b5.data_i        = (sel == 5) ? drv_data[4:0] : '0;
    assign b5.data_val_i    = (sel == 5) && drv_val;
    assign b5.mode_i        = drv_mode;
    assign b5.data_ready_i  = (sel == 5) && drv_ready;
    assign b16.data_i       = (sel == 16) ? drv_data[15:0] : '0;
    assign b16.data_val_i   = (sel == 16) && drv_val;
    assign b16.mode_i       = drv_mode;
    assign b16.data_ready_i = (sel == 16) && drv_ready;

    logic [63:0] o_data, o_idx;
    logic        o_last, o_empty, o_val, o_rdy;

    always_comb begin
        case (sel)
            5: begin
                o_data = 64'(b5.data_o);  o_idx = 64'(b5.index_o);
                o_last = b5.last_o; o_empty = b5.empty_o; o_val = b5.data_val_o; o_rdy = b5.data_ready_o;
            end
            16: begin
                o_data = 64'(b16.data_o); o_idx = 64'(b16.index_o);
                o_last = b16.last_o; o_empty = b16.empty_o; o_val = b16.data_val_o; o_rdy = b16.data_ready_o;
            end
            default: begin
                o_data = 64'(b8.data_o);  o_idx = 64'(b8.index_o);
                o_last = b8.last_o; o_empty = b8.empty_o; o_val = b8.data_val_o; o_rdy = b8.data_ready_o;
            end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_val"},   64'(o_val),   64'(0));
        check({tag, "_ready"}, 64'(o_rdy),   64'(1));
        check({tag, "_data"},  o_data,       64'(0));
        check({tag, "_index"}, o_idx,        64'(0));
        check({tag, "_last"},  64'(o_last),  64'(0));
        check({tag, "_empty"}, 64'(o_empty), 64'(0));
    endtask

    // One transaction; rmode: 0 always ready, 1 random ready, 2 ready pattern 1,0,0,...
    // Called at a negedge with the selected DUT idle; returns at a negedge after it is idle again.
    task automatic run_txn(input int w, input logic [63:0] vec, input logic mode, input int rmode);
        int   exp_q[$];
        bit   is_empty;
        int   n_exp, beats, k, idx;
        logic r;
        sel = w;
        #1;
        for (int i = 0; i < w; i++) begin
            if (vec[i]) begin
                if (mode) exp_q.push_front(i);
                else      exp_q.push_back(i);
            end
        end
        is_empty = (exp_q.size() == 0);
        if (is_empty) exp_q.push_back(0);
        n_exp = exp_q.size();
        check("ready_before_accept", 64'(o_rdy), 64'(1));
        drv_data = vec; drv_mode = mode; drv_val = 1'b1; drv_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        // Junk on the input side while scanning must be ignored.
        drv_data = {$urandom, $urandom};
        drv_mode = ~mode;
        beats = 0; k = 0;
        while (exp_q.size() > 0 && k < 4 * w + 16) begin
            idx = exp_q[0];
            check("beat_val",   64'(o_val), 64'(1));
            check("scan_ready", 64'(o_rdy), 64'(0));
            check("beat_data",  o_data, is_empty ? 64'(0) : (64'(1) << idx));
            check("beat_index", o_idx, 64'(idx));
            check("beat_last",  64'(o_last), 64'(exp_q.size() == 1));
            check("beat_empty", 64'(o_empty), 64'(is_empty));
            case (rmode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(2) != 0);
                default: r = ((k % 3) == 0);
            endcase
            drv_ready = r;
            if (r) begin
                void'(exp_q.pop_front());
                beats++;
                if (exp_q.size() == 0) drv_val = 1'b0;
            end
            k++;
            @(posedge clk); @(negedge clk);
        end
        check("beat_count", 64'(beats), 64'(n_exp));
        drv_val = 1'b0; drv_ready = 1'b0;
        check_idle("after_txn");
    endtask

    initial begin
        srst = 1'b1; sel = 8;
        drv_data = 64'hFF; drv_val = 1'b1; drv_mode = 1'b0; drv_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        drv_val = 1'b0; drv_ready = 1'b0; drv_data = '0;
        srst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // data_ready_o must not react to data_val_i or data_ready_i
        drv_val = 1'b1; drv_ready = 1'b1; #1;
        check("ready_static_idle_hi", 64'(o_rdy), 64'(1));
        drv_val = 1'b0; drv_ready = 1'b0; #1;
        check("ready_static_idle_lo", 64'(o_rdy), 64'(1));
        @(negedge clk);

        run_txn(8, 64'hA4, 1'b1, 0);
        run_txn(8, 64'hA4, 1'b0, 0);
        run_txn(8, 64'h00, 1'b0, 0);
        run_txn(8, 64'h00, 1'b1, 1);
        run_txn(8, 64'hFF, 1'b0, 2);
        run_txn(8, 64'hFF, 1'b1, 2);
        run_txn(8, 64'h80, 1'b0, 0);
        run_txn(8, 64'h01, 1'b1, 0);

        // Reset after the second beat of a full vector.
        sel = 8; #1;
        drv_data = 64'hFF; drv_mode = 1'b0; drv_val = 1'b1; drv_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        drv_val = 1'b0;
        check("rst_beat0_index", o_idx, 64'(0));
        drv_ready = 1'b1; #1;
        check("ready_static_scan_hi", 64'(o_rdy), 64'(0));
        drv_ready = 1'b0; #1;
        check("ready_static_scan_lo", 64'(o_rdy), 64'(0));
        drv_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_beat1_data", o_data, 64'h02);
        check("rst_beat1_index", o_idx, 64'(1));
        srst = 1'b1;
        @(posedge clk); @(negedge clk);
        srst = 1'b0; drv_ready = 1'b0;
        check_idle("mid_reset");
        run_txn(8, 64'h10, 1'b0, 0);

        for (int v = 0; v < 256; v++) begin
            run_txn(8, 64'(v), 1'b0, 1);
            run_txn(8, 64'(v), 1'b1, 1);
        end
        for (int t = 0; t < 200; t++)
            run_txn(5, 64'($urandom_range(31)), 1'($urandom_range(1)), 1);
        for (int t = 0; t < 200; t++)
            run_txn(16, 64'($urandom_range(65535)), 1'($urandom_range(1)), 1);
        run_txn(16, 64'hFFFF, 1'b1, 2);
        run_txn(5, 64'h1F, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/priority_scanner.md
Name: priority_scanner

Overview:
- Parametrised, sequential successor to the 4-bit left/right priority encoder.
- Accepts one WIDTH-bit request vector per transaction and emits every set bit as a separate output beat: one-hot plus binary index.
- Scan order is MSB-first (left) or LSB-first (right), selected per transaction.
- Used as a request serialiser in front of arbiters and interrupt or work queues; valid/ready on both sides.

Parameters:
- WIDTH, 8, request vector width; legal range 2..64.
- IDX_W, $clog2(WIDTH), index output width; derived, never overridden.

Ports:
- clk_i  input  1  system clock, rising edge.
- srst_i  input  1  synchronous reset, active-high.
- data_i  input  WIDTH  request vector.
- data_val_i  input  1  data_i/mode_i valid.
- mode_i  input  1  scan order: 0 = right-first (LSB), 1 = left-first (MSB).
- data_ready_o  output  1  block can accept a new vector.
- data_o  output  WIDTH  one-hot of the bit currently presented; all-zero on an empty beat.
- index_o  output  IDX_W  binary position of the bit in data_o; 0 on an empty beat.
- last_o  output  1  current beat is the final beat of the transaction.
- empty_o  output  1  transaction carried an all-zero vector.
- data_val_o  output  1  output beat valid.
- data_ready_i  input  1  downstream accepts the beat.

Behaviour:
- One clock, clk_i. srst_i is synchronous and active-high; all state updates on the rising edge of clk_i.
- Reset values:
  - FSM = IDLE; mask register = 0.
  - data_o = 0, index_o = 0, last_o = 0, empty_o = 0, data_val_o = 0.
  - data_ready_o = 1 (it follows IDLE).
  - Inputs are ignored in any cycle where srst_i = 1.
- FSM has two states, IDLE and SCAN.
- data_ready_o = (state == IDLE); it is a combinational decode of the state register only, with no path from data_val_i or data_ready_i.
- IDLE, on data_val_i & data_ready_o:
  - latch mask = data_i and dir = mode_i;
  - load the first beat into the output registers;
  - move to SCAN.
  - First beat has data_val_o = 1 in the cycle after acceptance (latency 1).
- Beat formation from the current mask:
  - dir = 1: selected bit is the highest set bit; dir = 0: the lowest set bit.
  - data_o = one-hot of the selected bit; index_o = its position.
  - last_o = 1 when mask has exactly one set bit.
  - mask == 0 (only possible on the first beat): data_o = 0, index_o = 0, last_o = 1, empty_o = 1.
- SCAN:
  - While data_val_o & !data_ready_i, every output holds stable (no change to data_o, index_o, last_o, empty_o).
  - On data_val_o & data_ready_i with last_o = 0: clear the served bit from mask and load the next beat in the same edge. data_val_o stays 1 and beats are back-to-back, giving 1 beat/cycle.
  - On data_val_o & data_ready_i with last_o = 1: data_val_o goes to 0, all outputs go to 0, and the FSM returns to IDLE.
- A transaction with N set bits occupies N output cycles (minimum) plus 1 IDLE cycle before the next accept. An empty vector occupies 1 beat.
- mode_i is sampled only at acceptance. A change of mode_i mid-transaction has no effect.
- data_i and data_val_i are ignored while in SCAN; the source must hold them, per valid/ready rules.
- Index arithmetic: index_o is unsigned, zero-extended to IDX_W. For WIDTH a power of two, bit WIDTH-1 gives index all-ones.
- srst_i mid-transaction: the remaining beats are discarded and the next cycle is the reset state, with no partial beat.
- Single-bit vectors: the first beat has last_o = 1. Full vector (all ones): WIDTH beats in strict order, last on bit 0 (left-first) or bit WIDTH-1 (right-first).
- Static check: the bench confirms that data_ready_o has no combinational path from data_val_i or data_ready_i.

Test Plan:
- WIDTH=8, data_i=8'b1010_0100, mode_i=1, data_ready_i=1 -> beats data_o 1000_0000/idx 7, 0010_0000/idx 5, 0000_0100/idx 2; last_o only on the third beat; data_val_o high for 3 consecutive cycles starting 1 cycle after accept.
- Same vector with mode_i=0 -> beats idx 2, 5, 7; last_o on idx 7; the next accept is possible 1 cycle after the final handshake.
- data_i=8'h00, either mode -> single beat: data_o=0, index_o=0, last_o=1, empty_o=1; then IDLE.
- data_i=8'hFF, mode_i=0, data_ready_i toggling 1,0,0,1,... -> 8 beats idx 0..7 in order; outputs stable during every stall; no beat lost or duplicated; data_ready_o=0 throughout.
- srst_i pulsed for 1 cycle after the 2nd beat of 8'hFF -> the next cycle shows data_val_o=0, all outputs 0, data_ready_o=1; a fresh 8'b0001_0000 then yields a single beat idx 4 with last_o=1.
- Exhaustive: all 256 vectors × both modes with random data_ready_i, plus 200 random transactions at WIDTH=5 and WIDTH=16 -> the beat sequence matches the reference model (ordered list of set-bit indices) and the beat count equals max(popcount, 1).
